bf_processor: RTL and testbench

- Self-contained Brainfuck interpreter core with a built-in 8N1 UART.
- While `loading` is high, program bytes arriving on `rx` are stored in program memory.
- When `loading` falls, the program executes against a byte-cell data memory. `.` transmits on `tx` and `,` receives from `rx`.
- `done` flags program termination. Sits at top level between a host UART link and board pins.

---
 rtl/bf_processor.sv | 274 +++++++++++++++++++++++++++
 tb/tb_bf_processor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bf_processor.sv
// Brainfuck interpreter core with built-in 8N1 UART for program upload and I/O.
// Latency: one instruction per sysClk cycle; '.' stalls while TX busy, ',' stalls until an RX byte arrives.
// Backpressure: no handshake; UART timing follows the uartClk bit strobe, load bytes past capacity are dropped.
module bf_processor #(
   parameter int DATA_ADDR_W = 8,
   parameter int PROG_ADDR_W = 10
) (
   input  logic sysClk,
   input  logic extReset_full,
   input  logic extReset_proc,
   input  logic uartClk,
   input  logic loading,
   input  logic rx,
   output logic tx,
   output logic done
);

   localparam int LP_CELLS = 1 << DATA_ADDR_W;
   localparam int LP_PROG  = 1 << PROG_ADDR_W;
   localparam logic [PROG_ADDR_W:0] LP_LEN_MAX = {1'b1, {PROG_ADDR_W{1'b0}}};
   localparam logic [PROG_ADDR_W:0] LP_ONE     = {{PROG_ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_RUN,
      ST_SCAN_FWD,
      ST_SCAN_BACK,
      ST_HALTED
   } state_t;

   // Execution and TX are held idle while loading; RX must keep working so it
   // only answers to the explicit resets.
   logic w_exec_rst;
   logic w_rx_rst;
   assign w_exec_rst = extReset_full | extReset_proc | loading;
   assign w_rx_rst   = extReset_full | extReset_proc;

   logic [2:0] r_uclk_s;
   logic [1:0] r_rx_s;
   logic       w_tick;
   logic       w_rx_bit;

   // Synchronise the bit strobe and rx line into the sysClk domain.
   always_ff @(posedge sysClk) begin
      if (w_rx_rst) begin
         r_uclk_s <= '0;
         r_rx_s   <= 2'b11;
      end else begin
         r_uclk_s <= {r_uclk_s[1:0], uartClk};
         r_rx_s   <= {r_rx_s[0], rx};
      end
   end

   assign w_tick   = r_uclk_s[1] & ~r_uclk_s[2];
   assign w_rx_bit = r_rx_s[1];

   // ---------------------------------------------------------------- UART RX
   logic [3:0] r_rx_cnt;
   logic [7:0] r_rx_sh;
   logic       r_rx_vld;
   logic [7:0] r_rx_dat;

   // Receiver: cnt 0 = idle, 1..8 = data bits, 9 = stop bit check.
   always_ff @(posedge sysClk) begin
      if (w_rx_rst) begin
         r_rx_cnt <= '0;
         r_rx_sh  <= '0;
         r_rx_vld <= 1'b0;
         r_rx_dat <= '0;
      end else begin
         r_rx_vld <= 1'b0;
         if (w_tick) begin
            if (r_rx_cnt == 4'd0) begin
               if (!w_rx_bit) r_rx_cnt <= 4'd1;
            end else if (r_rx_cnt == 4'd9) begin
               r_rx_cnt <= 4'd0;
               if (w_rx_bit) begin
                  r_rx_vld <= 1'b1;
                  r_rx_dat <= r_rx_sh;
               end
            end else begin
               r_rx_sh  <= {w_rx_bit, r_rx_sh[7:1]};
               r_rx_cnt <= r_rx_cnt + 4'd1;
            end
         end
      end
   end

   // ---------------------------------------------------------------- UART TX
   logic       r_tx_busy;
   logic [3:0] r_tx_cnt;
   logic [9:0] r_tx_sh;
   logic       r_tx;
   logic       w_tx_start;
   logic [7:0] w_cell;

   // Transmitter: ten bits leave on ten ticks, the eleventh tick ends the stop bit.
   always_ff @(posedge sysClk) begin
      if (w_exec_rst) begin
         r_tx_busy <= 1'b0;
         r_tx_cnt  <= '0;
         r_tx_sh   <= '1;
         r_tx      <= 1'b1;
      end else if (w_tx_start) begin
         r_tx_busy <= 1'b1;
         r_tx_cnt  <= '0;
         r_tx_sh   <= {1'b1, w_cell, 1'b0};
      end else if (r_tx_busy && w_tick) begin
         if (r_tx_cnt == 4'd10) begin
            r_tx_busy <= 1'b0;
         end else begin
            r_tx     <= r_tx_sh[0];
            r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
            r_tx_cnt <= r_tx_cnt + 4'd1;
         end
      end
   end

   assign tx = r_tx;

   // ---------------------------------------------------------- program store
   logic [7:0]             r_prog [LP_PROG];
   logic [PROG_ADDR_W:0]   r_prog_len;
   logic                   r_loading_q;

   // Program upload; the length doubles as the load address.
   always_ff @(posedge sysClk) begin
      if (extReset_full) begin
         r_prog_len  <= '0;
         r_loading_q <= 1'b0;
         for (int i = 0; i < LP_PROG; i++) r_prog[i] <= '0;
      end else begin
         r_loading_q <= loading;
         if (loading && !r_loading_q) begin
            r_prog_len <= '0;
         end else if (loading && r_rx_vld && (r_prog_len != LP_LEN_MAX)) begin
            r_prog[r_prog_len[PROG_ADDR_W-1:0]] <= r_rx_dat;
            r_prog_len <= r_prog_len + 1'b1;
         end
      end
   end

   // -------------------------------------------------------------- execution
   state_t                 r_state, w_state_nxt;
   logic [PROG_ADDR_W:0]   r_pc, w_pc_nxt;
   logic [PROG_ADDR_W:0]   r_depth, w_depth_nxt;
   logic [DATA_ADDR_W-1:0] r_ptr, w_ptr_nxt;
   logic [7:0]             r_cells [LP_CELLS];
   logic                   w_cell_we;
   logic [7:0]             w_cell_wdat;
   logic [7:0]             w_instr;

   assign w_instr = r_prog[r_pc[PROG_ADDR_W-1:0]];
   assign w_cell  = r_cells[r_ptr];
   assign done    = (r_state == ST_HALTED);

   // FSM state register.
   always_ff @(posedge sysClk) begin
      if (w_exec_rst) r_state <= ST_RUN;
      else            r_state <= w_state_nxt;
   end

   // Datapath registers: PC, pointer, bracket depth and data cells.
   always_ff @(posedge sysClk) begin
      if (w_exec_rst) begin
         r_pc    <= '0;
         r_ptr   <= '0;
         r_depth <= '0;
         for (int i = 0; i < LP_CELLS; i++) r_cells[i] <= '0;
      end else begin
         r_pc    <= w_pc_nxt;
         r_ptr   <= w_ptr_nxt;
         r_depth <= w_depth_nxt;
         if (w_cell_we) r_cells[r_ptr] <= w_cell_wdat;
      end
   end

   // Instruction decode, bracket scanning and termination.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_ptr_nxt   = r_ptr;
      w_depth_nxt = r_depth;
      w_cell_we   = 1'b0;
      w_cell_wdat = w_cell;
      w_tx_start  = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (r_pc == r_prog_len) begin
               w_state_nxt = ST_HALTED;
            end else begin
               case (w_instr)
                  8'h2B: begin
                     w_cell_we   = 1'b1;
                     w_cell_wdat = w_cell + 8'd1;
                     w_pc_nxt    = r_pc + 1'b1;
                  end
                  8'h2D: begin
                     w_cell_we   = 1'b1;
                     w_cell_wdat = w_cell - 8'd1;
                     w_pc_nxt    = r_pc + 1'b1;
                  end
                  8'h3E: begin
                     w_ptr_nxt = r_ptr + 1'b1;
                     w_pc_nxt  = r_pc + 1'b1;
                  end
                  8'h3C: begin
                     w_ptr_nxt = r_ptr - 1'b1;
                     w_pc_nxt  = r_pc + 1'b1;
                  end
                  8'h2E: begin
                     if (!r_tx_busy) begin
                        w_tx_start = 1'b1;
                        w_pc_nxt   = r_pc + 1'b1;
                     end
                  end
                  8'h2C: begin
                     if (r_rx_vld) begin
                        w_cell_we   = 1'b1;
                        w_cell_wdat = r_rx_dat;
                        w_pc_nxt    = r_pc + 1'b1;
                     end
                  end
                  8'h5B: begin
                     w_pc_nxt = r_pc + 1'b1;
                     if (w_cell == 8'd0) begin
                        w_state_nxt = ST_SCAN_FWD;
                        w_depth_nxt = LP_ONE;
                     end
                  end
                  8'h5D: begin
                     if (w_cell == 8'd0) begin
                        w_pc_nxt = r_pc + 1'b1;
                     end else if (r_pc == '0) begin
                        w_state_nxt = ST_HALTED;
                     end else begin
                        w_state_nxt = ST_SCAN_BACK;
                        w_depth_nxt = LP_ONE;
                        w_pc_nxt    = r_pc - 1'b1;
                     end
                  end
                  default: w_pc_nxt = r_pc + 1'b1;
               endcase
            end
         end
         ST_SCAN_FWD: begin
            if (r_pc >= r_prog_len) begin
               w_state_nxt = ST_HALTED;
            end else begin
               w_pc_nxt = r_pc + 1'b1;
               if (w_instr == 8'h5B) begin
                  w_depth_nxt = r_depth + 1'b1;
               end else if (w_instr == 8'h5D) begin
                  w_depth_nxt = r_depth - 1'b1;
                  if (r_depth == LP_ONE) w_state_nxt = ST_RUN;
               end
            end
         end
         ST_SCAN_BACK: begin
            if ((w_instr == 8'h5B) && (r_depth == LP_ONE)) begin
               w_state_nxt = ST_RUN;
               w_depth_nxt = '0;
               w_pc_nxt    = r_pc + 1'b1;
            end else begin
               if (w_instr == 8'h5B) w_depth_nxt = r_depth - 1'b1;
               if (w_instr == 8'h5D) w_depth_nxt = r_depth + 1'b1;
               if (r_pc == '0) w_state_nxt = ST_HALTED;
               else            w_pc_nxt    = r_pc - 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bf_processor.sv
// Testbench for bf_processor: loads programs over rx and decodes frames from tx.
// Expected tx bytes are queued by the stimulus and consumed by a frame monitor.
// All waits are bounded by cycle budgets.
module tb_bf_processor;

   logic sysClk        = 1'b0;
   logic extReset_full = 1'b1;
   logic extReset_proc = 1'b0;
   logic uartClk       = 1'b0;
   logic loading       = 1'b0;
   logic rx            = 1'b1;
   logic tx;
   logic done;

   int         n_vec  = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];

   bf_processor #(.DATA_ADDR_W(3), .PROG_ADDR_W(4)) dut (
      .sysClk        (sysClk),
      .extReset_full (extReset_full),
      .extReset_proc (extReset_proc),
      .uartClk       (uartClk),
      .loading       (loading),
      .rx            (rx),
      .tx            (tx),
      .done          (done)
   );

   always #5  sysClk  = ~sysClk;
   always #30 uartClk = ~uartClk;

   task automatic check_bit(input string name, input logic act, input logic req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, req);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // One 8N1 frame on rx, each bit one uartClk period, changing on the falling edge.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge uartClk); rx = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge uartClk); rx = b[i];
      end
      @(negedge uartClk); rx = stop_bit;
      @(negedge uartClk); rx = 1'b1;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
   endtask

   task automatic begin_load();
      @(negedge sysClk); loading = 1'b1;
      repeat (2) @(negedge sysClk);
      check_bit("done_low_while_loading", done, 1'b0);
   endtask

   task automatic end_load();
      repeat (2) @(negedge sysClk);
      loading = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int k = 0;
      while (done !== 1'b1 && k < budget) begin
         @(negedge sysClk);
         k++;
      end
      check_bit(name, done, 1'b1);
   endtask

   // Wait for all expected frames, then watch a while for stray frames.
   task automatic drain(input string name);
      int k = 0;
      while (exp_q.size() != 0 && k < 30000) begin
         @(negedge sysClk);
         k++;
      end
      repeat (14) @(negedge uartClk);
      check_int({name, "_frames_left"}, exp_q.size(), 0);
      check_bit({name, "_tx_idle"}, tx, 1'b1);
      exp_q.delete();
   endtask

   task automatic push_count_up();
      for (int i = 1; i <= 255; i++) exp_q.push_back(8'(i));
   endtask

   // Frame monitor: tx bits change just after a uartClk rise, so sample on the next rise.
   initial begin
      logic [7:0] b;
      logic [7:0] e;
      logic       sb;
      forever begin
         @(posedge uartClk);
         if (tx === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
               @(posedge uartClk); b[i] = tx;
            end
            @(posedge uartClk); sb = tx;
            n_vec++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL tx_frame: got unexpected byte %02h, expected no frame", b);
            end else begin
               e = exp_q.pop_front();
               if (b !== e || sb !== 1'b1) begin
                  n_fail++;
                  $display("FAIL tx_frame: got %02h stop %b, expected %02h stop 1", b, sb, e);
               end
            end
         end
      end
   end

   // Directed stimulus.
   initial begin
      repeat (3) @(negedge sysClk);
      check_bit("reset_tx", tx, 1'b1);
      check_bit("reset_done", done, 1'b0);
      extReset_full = 1'b0;
      repeat (3) @(negedge sysClk);
      check_bit("empty_prog_done", done, 1'b1);
      check_bit("empty_prog_tx", tx, 1'b1);

      // Counting loop: 0x01..0xFF.
      begin_load();
      send_str("+[.+]");
      push_count_up();
      end_load();
      wait_done("loop_done", 30000);
      drain("loop");

      // Re-run the kept program after an execution-only reset.
      @(negedge sysClk); extReset_proc = 1'b1;
      @(negedge sysClk);
      check_bit("proc_reset_done", done, 1'b0);
      check_bit("proc_reset_tx", tx, 1'b1);
      push_count_up();
      extReset_proc = 1'b0;
      wait_done("rerun_done", 30000);
      drain("rerun");

      // Echo one byte.
      begin_load();
      send_str(",.");
      end_load();
      exp_q.push_back(8'h41);
      repeat (50) @(negedge sysClk);
      check_bit("echo_waiting_rx", done, 1'b0);
      send_byte(8'h41, 1'b1);
      wait_done("echo_done", 2000);
      drain("echo");

      // Pointer wraps below zero onto cell 7 (8 cells).
      begin_load();
      send_str(">>>+<<<<.");
      exp_q.push_back(8'h00);
      end_load();
      wait_done("wrap_done", 2000);
      drain("wrap");

      // Nested forward skip, then decrement wraps the cell to 0xFF.
      begin_load();
      send_str("[[.]]-.");
      exp_q.push_back(8'hFF);
      end_load();
      wait_done("skip_done", 2000);
      drain("skip");

      // Bad stop bit: the middle '+' is discarded.
      begin_load();
      send_byte(8'h2B, 1'b1);
      send_byte(8'h2B, 1'b0);
      send_byte(8'h2E, 1'b1);
      exp_q.push_back(8'h01);
      end_load();
      wait_done("badstop_done", 2000);
      drain("badstop");

      // 17 bytes into a 16-byte store: the trailing '.' is dropped.
      begin_load();
      send_str("+++++++++++++++..");
      exp_q.push_back(8'h0F);
      end_load();
      wait_done("sat_done", 2000);
      drain("sat");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
